// File: rtl/rams_sdp_3d_reader.sv
// Purpose: bank-major read sequencer for the multi-bank SDP accumulation RAM, streaming words out with bank/addr/last tags.
// Latency: start in cycle t -> enb in t+1 -> doutb in t+2 -> m_valid in t+3; one word per cycle sustained after that.
// Backpressure: reads are issued only when the 4-entry output FIFO can still hold them, so it never overflows under any m_ready pattern.
module rams_sdp_3d_reader #(
    parameter int NUM_RAMS = 2,
    parameter int A_WID    = 10,
    parameter int D_WID    = 32,
    localparam int B_WID   = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [A_WID:0]              len,
    input  logic [NUM_RAMS-1:0]         bank_mask,
    output logic [NUM_RAMS-1:0]         enb,
    output logic [NUM_RAMS*A_WID-1:0]   addrb,
    input  logic [NUM_RAMS*D_WID-1:0]   doutb,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [D_WID-1:0]            m_data,
    output logic [B_WID-1:0]            m_bank,
    output logic [A_WID-1:0]            m_addr,
    output logic                        m_last,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [D_WID-1:0] data;
        logic [B_WID-1:0] bank;
        logic [A_WID-1:0] addr;
        logic             last;
    } beat_t;

    localparam logic [A_WID:0] LEN_ONE = {{A_WID{1'b0}}, 1'b1};

    state_t state_q, state_d;

    // Sweep parameters and walk pointer (pointer always names the next read to issue in RUN)
    logic [A_WID:0]        len_q;
    logic [NUM_RAMS-1:0]   mask_q;
    logic [B_WID-1:0]      cur_bank;
    logic [A_WID-1:0]      cur_addr;

    // Issue decode
    logic                  start_ok, start_go, start_empty;
    logic                  issue, credit_ok, done_d;
    logic [A_WID:0]        use_len;
    logic [NUM_RAMS-1:0]   use_mask;
    logic [B_WID-1:0]      first_bank, iss_bank, nxt_bank;
    logic [A_WID-1:0]      iss_addr;
    logic                  bank_end, nxt_found, iss_final;
    logic [NUM_RAMS-1:0]   enb_d;

    // Read pipeline: stage 1 = enb/addrb registered, stage 2 = doutb valid
    logic [NUM_RAMS-1:0]   enb_q;
    logic [A_WID-1:0]      addr_q;
    logic                  s1_vld, s1_last;
    logic [B_WID-1:0]      s1_bank;
    logic                  s2_vld, s2_last;
    logic [B_WID-1:0]      s2_bank;
    logic [A_WID-1:0]      s2_addr;
    logic [1:0]            pend;

    // Output FIFO
    beat_t                 mem [4];
    beat_t                 head, push_beat;
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_cnt;
    logic                  push, pop;
    logic                  done_q;

    assign pend     = {1'b0, s1_vld} + {1'b0, s2_vld};
    assign push     = s2_vld;
    assign head     = mem[rd_ptr];
    assign m_valid  = (fifo_cnt != 3'd0);
    assign pop      = m_valid & m_ready;
    assign m_data   = head.data;
    assign m_bank   = head.bank;
    assign m_addr   = head.addr;
    assign m_last   = head.last;
    assign enb      = enb_q;
    assign addrb    = {NUM_RAMS{addr_q}};
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

    // Credit check: words already queued + reads in flight + this read must fit, counting this cycle's pop
    assign credit_ok = (({1'b0, fifo_cnt} + {2'b00, pend} + 4'd1) <= (4'd4 + {3'b000, pop}));

    // Lowest enabled bank of the incoming mask, used as the first bank of a new sweep
    always_comb begin
        first_bank = '0;
        for (int i = NUM_RAMS - 1; i >= 0; i--) begin
            if (bank_mask[i]) first_bank = B_WID'(i);
        end
    end

    // Select the read to issue this cycle and work out where the walk goes after it
    always_comb begin
        if (state_q == IDLE) begin
            use_len  = len;
            use_mask = bank_mask;
            iss_bank = first_bank;
            iss_addr = '0;
        end else begin
            use_len  = len_q;
            use_mask = mask_q;
            iss_bank = cur_bank;
            iss_addr = cur_addr;
        end
        bank_end  = ({1'b0, iss_addr} == (use_len - LEN_ONE));
        nxt_bank  = iss_bank;
        nxt_found = 1'b0;
        for (int i = NUM_RAMS - 1; i >= 0; i--) begin
            if (use_mask[i] && (i > int'(iss_bank))) begin
                nxt_bank  = B_WID'(i);
                nxt_found = 1'b1;
            end
        end
        iss_final = bank_end && !nxt_found;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: the first read goes out in the start cycle itself, so a one-word sweep jumps straight to DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = iss_final ? DRAIN : RUN;
            RUN:     if (issue && iss_final) state_d = DRAIN;
            DRAIN:   if (pop && head.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: read issue, one-hot enable, and done request
    always_comb begin
        start_ok    = (state_q == IDLE) && start;
        start_empty = start_ok && ((len == '0) || (bank_mask == '0));
        start_go    = start_ok && !start_empty;
        issue       = start_go || ((state_q == RUN) && credit_ok);
        done_d      = start_empty || ((state_q == DRAIN) && pop && head.last);
        enb_d       = '0;
        for (int i = 0; i < NUM_RAMS; i++) begin
            if (issue && (int'(iss_bank) == i)) enb_d[i] = 1'b1;
        end
    end

    // Latch sweep parameters on start and advance the walk pointer on every issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            mask_q   <= '0;
            cur_bank <= '0;
            cur_addr <= '0;
        end else if (issue) begin
            if (start_go) begin
                len_q  <= len;
                mask_q <= bank_mask;
            end
            if (bank_end) begin
                cur_addr <= '0;
                cur_bank <= nxt_bank;
            end else begin
                cur_addr <= iss_addr + 1'b1;
                cur_bank <= iss_bank;
            end
        end
    end

    // Read pipeline: carry bank/addr/last alongside the RAM's one-cycle read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enb_q   <= '0;
            addr_q  <= '0;
            s1_vld  <= 1'b0;
            s1_bank <= '0;
            s1_last <= 1'b0;
            s2_vld  <= 1'b0;
            s2_bank <= '0;
            s2_addr <= '0;
            s2_last <= 1'b0;
        end else begin
            enb_q  <= enb_d;
            s1_vld <= issue;
            if (issue) begin
                addr_q  <= iss_addr;
                s1_bank <= iss_bank;
                s1_last <= iss_final;
            end
            s2_vld  <= s1_vld;
            s2_bank <= s1_bank;
            s2_addr <= addr_q;
            s2_last <= s1_last;
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.data = doutb[int'(s2_bank) * D_WID +: D_WID];
        push_beat.bank = s2_bank;
        push_beat.addr = s2_addr;
        push_beat.last = s2_last;
    end

    // Output FIFO storage and pointers; push and pop may coincide even when full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 3'd1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 3'd1;
        end
    end

    // done pulses the cycle after the final transfer, or after an empty start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= done_d;
    end

endmodule

// File: tb/tb_rams_sdp_3d_reader.sv
module tb_rams_sdp_3d_reader;
    localparam int NR = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW:0]       len;
    logic [NR-1:0]     bank_mask;
    logic [NR-1:0]     enb;
    logic [NR*AW-1:0]  addrb;
    logic [NR*DW-1:0]  doutb;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [BW-1:0]     m_bank;
    logic [AW-1:0]     m_addr;
    logic              m_last;
    logic              busy;
    logic              done;

    rams_sdp_3d_reader #(.NUM_RAMS(NR), .A_WID(AW), .D_WID(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bank_mask(bank_mask),
        .enb(enb), .addrb(addrb), .doutb(doutb),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_bank(m_bank),
        .m_addr(m_addr), .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM model: mem[b][a] = b*1000 + a, registered read
    logic [DW-1:0] rd0 = '0, rd1 = '0;
    always @(posedge clk) begin
        if (enb[0]) rd0 <= 32'(addrb[AW-1:0]);
        if (enb[1]) rd1 <= 32'd1000 + 32'(addrb[2*AW-1:AW]);
    end
    assign doutb = {rd1, rd0};

    typedef struct {
        int bank;
        int addr;
        int data;
        bit last;
        int cyc;
    } beat_s;

    beat_s beats[$];
    int    iss_bank_q[$];
    int    iss_addr_q[$];
    int    cyc = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    stall_viol = 0;
    int    enb_bad = 0;
    int    addr_split = 0;
    bit    prev_stall = 0;
    logic [DW-1:0] p_data;
    logic [BW-1:0] p_bank;
    logic [AW-1:0] p_addr;
    logic          p_last;

    // Monitor: record transfers, issued reads, done pulses and stall stability
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!m_valid || m_data !== p_data || m_bank !== p_bank ||
                               m_addr !== p_addr || m_last !== p_last))
                stall_viol++;
            prev_stall = m_valid && !m_ready;
            p_data = m_data; p_bank = m_bank; p_addr = m_addr; p_last = m_last;
            if (m_valid && m_ready)
                beats.push_back('{int'(m_bank), int'(m_addr), int'(m_data), m_last, cyc});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (enb != '0) begin
                if (enb == 2'b01) begin
                    iss_bank_q.push_back(0);
                    iss_addr_q.push_back(int'(addrb[AW-1:0]));
                end else if (enb == 2'b10) begin
                    iss_bank_q.push_back(1);
                    iss_addr_q.push_back(int'(addrb[2*AW-1:AW]));
                end else begin
                    enb_bad++;
                end
                if (addrb[AW-1:0] !== addrb[2*AW-1:AW]) addr_split++;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int ln, input int mask);
        @(posedge clk); #1;
        beats.delete();
        iss_bank_q.delete();
        iss_addr_q.delete();
        len       = (AW+1)'(ln);
        bank_mask = NR'(mask);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 1);
    endtask

    task automatic verify_seq(input string tag, input int ln, input int mask);
        int idx, bad, ibad, lasts, hb;
        idx = 0; bad = 0; ibad = 0; lasts = 0;
        hb  = mask[1] ? 1 : 0;
        for (int b = 0; b < NR; b++) begin
            if (mask[b]) begin
                for (int a = 0; a < ln; a++) begin
                    if (idx < beats.size()) begin
                        if (beats[idx].bank != b || beats[idx].addr != a ||
                            beats[idx].data != b*1000 + a ||
                            beats[idx].last != (b == hb && a == ln - 1))
                            bad++;
                    end
                    if (idx < iss_bank_q.size()) begin
                        if (iss_bank_q[idx] != b || iss_addr_q[idx] != a) ibad++;
                    end
                    idx++;
                end
            end
        end
        foreach (beats[i]) if (beats[i].last) lasts++;
        check({tag, "_beat_count"}, beats.size(), idx);
        check({tag, "_beat_order"}, bad, 0);
        check({tag, "_issue_count"}, iss_bank_q.size(), idx);
        check({tag, "_issue_order"}, ibad, 0);
        check({tag, "_last_count"}, lasts, 1);
    endtask

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int d0, sz8, sz18, stall_enb, k;
        rst = 1'b1; start = 1'b0; len = '0; bank_mask = '0; m_ready = 1'b0;
        #12;
        check("rst_m_valid", m_valid, 0);
        check("rst_enb", enb, 0);
        check("rst_addrb", addrb, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_tags", {m_bank, m_addr, m_last}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic sweep, m_ready held high
        m_ready = 1'b1;
        d0 = done_cnt;
        do_start(4, 3);
        check("basic_enb_t1", enb, 1);
        check("basic_busy_t1", busy, 1);
        check("basic_valid_t1", m_valid, 0);
        @(posedge clk); #1;
        check("basic_valid_t2", m_valid, 0);
        @(posedge clk); #1;
        check("basic_valid_t3", m_valid, 1);
        check("basic_data_t3", m_data, 0);
        wait_done("basic", 50);
        check("basic_busy_at_done", busy, 0);
        verify_seq("basic", 4, 3);
        check("basic_no_bubble", (beats.size() == 8) ? beats[7].cyc - beats[0].cyc : -1, 7);
        check("basic_done_lag", (beats.size() > 0) ? done_cyc - beats[beats.size()-1].cyc : -1, 1);
        check("basic_done_pulses", done_cnt - d0, 1);
        @(posedge clk); #1;
        check("basic_done_low", done, 0);

        // Backpressure: 1,0,0,1 pattern with a 10-cycle stall mid-sweep
        m_ready    = 1'b0;
        stall_viol = 0;
        stall_enb  = 0;
        sz8 = 0; sz18 = 0;
        d0 = done_cnt;
        do_start(4, 3);
        k = 1;
        m_ready = pat[1];
        while (done_cnt == d0 && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (k >= 8 && k <= 17) m_ready = 1'b0;
            else                   m_ready = pat[k % 4];
            if (k == 8)  sz8  = beats.size();
            if (k == 18) sz18 = beats.size();
            if (k >= 13 && k <= 17 && enb != '0) stall_enb++;
        end
        check("bp_done_seen", done_cnt - d0, 1);
        check("bp_stall_no_xfer", sz18 - sz8, 0);
        check("bp_enb_stopped", stall_enb, 0);
        check("bp_stable", stall_viol, 0);
        verify_seq("bp", 4, 3);

        // Mask skip and full depth
        m_ready    = 1'b1;
        addr_split = 0;
        enb_bad    = 0;
        do_start(1024, 2);
        wait_done("full", 1300);
        verify_seq("full", 1024, 2);
        check("full_no_bubble", (beats.size() == 1024) ? beats[1023].cyc - beats[0].cyc : -1, 1023);
        check("full_addr_split", addr_split, 0);
        check("full_enb_onehot", enb_bad, 0);

        // Empty sweeps: len=0, then mask=0
        d0 = done_cnt;
        do_start(0, 3);
        check("empty_len_done", done, 1);
        check("empty_len_busy", busy, 0);
        @(posedge clk); #1;
        check("empty_len_done_low", done, 0);
        do_start(4, 0);
        check("empty_mask_done", done, 1);
        check("empty_mask_busy", busy, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("empty_mask_done_low", done, 0);
        check("empty_no_enb", iss_bank_q.size(), 0);
        check("empty_done_pulses", done_cnt - d0, 2);

        // Start while busy is ignored
        d0 = done_cnt;
        do_start(4, 3);
        @(posedge clk); #1;
        len = 11'd2; bank_mask = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start", 50);
        verify_seq("busy_start", 4, 3);
        check("busy_start_done_pulses", done_cnt - d0, 1);

        // Mid-sweep reset after 5 beats
        do_start(4, 3);
        for (int j = 0; j < 50 && beats.size() < 5; j++) begin
            @(negedge clk); #1;
        end
        check("rst_mid_beats", beats.size(), 5);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", m_valid, 0);
        check("rst_mid_enb", enb, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_data", m_data, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_idle_valid", m_valid, 0);
        do_start(4, 3);
        wait_done("post_rst", 50);
        verify_seq("post_rst", 4, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rams_sdp_3d_reader.md
Name: rams_sdp_3d_reader

Overview:
- Read-side sequencer for the multi-bank simple dual-port accumulation RAM (NUM_RAMS banks, one read port per bank).
- On a start pulse it walks the selected banks bank-major (bank b, address 0..len-1, then the next enabled bank).
- Drives the per-bank enb/addrb, absorbs the one-cycle registered read latency, and streams words out on a valid/ready interface with full backpressure.
- Feeds spectral readout/export logic downstream of the cyclostationary accumulators.

Parameters:
- NUM_RAMS, 2, number of banks.
- A_WID, 10, bank address width; bank depth 2**A_WID.
- D_WID, 32, word width.

Ports:
- clk  in  1  single clock; the RAM read port is on this clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle start request; accepted only while busy=0.
- len  in  A_WID+1  words per bank, 0..2**A_WID; sampled when start is accepted.
- bank_mask  in  NUM_RAMS  banks to read (bit i = bank i); sampled with start.
- enb  out  NUM_RAMS  one-hot RAM read enable, registered.
- addrb  out  A_WID x NUM_RAMS  read address; every element carries the same registered address.
- doutb  in  D_WID x NUM_RAMS  RAM read data, valid the cycle after enb.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept; transfer occurs when m_valid & m_ready.
- m_data  out  D_WID  word.
- m_bank  out  $clog2(NUM_RAMS) (min 1)  source bank of word.
- m_addr  out  A_WID  source address of word.
- m_last  out  1  final word of the whole sweep.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the final word transfers, or immediately for an empty sweep.

Behaviour:
- Reset values: enb=0, addrb=0, m_valid=0, m_data=0, m_bank=0, m_addr=0, m_last=0, busy=0, done=0. FIFO, pending counter and FSM are cleared.
- FSM has three states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start when len≠0 and bank_mask≠0. The current bank is loaded with the lowest set mask bit and the address with 0.
  - If len==0 or mask==0, stay in IDLE and pulse done in the next cycle. busy stays 0.
  - RUN→DRAIN after the last read (last enabled bank, addr len-1) has been issued.
  - DRAIN→IDLE on the m_last transfer. done pulses in the cycle after that transfer, and busy drops in the same cycle.
- Issue path:
  - enb and addrb are registered. The cycle after a read is issued, enb[bank]=1 for exactly that bank.
  - Address increments per issue. When it reaches len-1 it wraps to 0 and bank advances to the next higher set mask bit; disabled banks are skipped.
- Latency: start in cycle t → enb in t+1 → doutb in t+2 → captured into output FIFO at end of t+2 → m_valid first high in t+3.
- Output FIFO:
  - 4 entries, each holding data, bank, addr and last.
  - Bank, addr and last are delayed alongside the read so that m_data = doutb[bank] of the matching read.
- Credit rule:
  - A read may be issued only if fifo_count + pending - pop + 1 ≤ 4.
  - pending is the number of reads in enb/doutb stages (0..2). pop = m_valid & m_ready this cycle.
  - FIFO must never overflow. With m_ready held 1, one word per cycle is sustained with no bubbles after the first.
- m_valid is high whenever the FIFO is non-empty. m_data, m_bank, m_addr and m_last are held stable while m_valid=1 and m_ready=0.
- Simultaneous push and pop on a full FIFO is legal. Count is unchanged.
- start while busy=1 is ignored; no state change.
- Exactly one m_last per non-empty sweep.
- Reset mid-sweep: all outputs return to reset values immediately. In-flight data is discarded; no done pulse.

Test Plan:
- Basic sweep: NUM_RAMS=2, RAM preloaded mem[b][a]=b*1000+a, len=4, mask=2'b11, m_ready=1.
  - m_valid is first high 3 cycles after start.
  - 8 consecutive beats: 0,1,2,3,1000,1001,1002,1003.
  - m_last only on 1003; done pulses the next cycle.
- Backpressure: same preload; m_ready toggles 1,0,0,1 repeating; also m_ready=0 for 10 cycles mid-sweep.
  - Sequence is identical to the basic sweep with no drop or duplicate.
  - Outputs are stable during stall; enb stops within 2 cycles of the FIFO filling.
- Mask skip and full depth: mask=2'b10, len=1024.
  - Only enb[1] ever asserts.
  - addrb runs 0..1023; 1024 beats with m_bank=1; m_last on addr 1023.
- Empty sweep: len=0, then mask=0.
  - done pulses one cycle after start; busy stays 0; enb never asserts.
- Start while busy and mid-sweep reset:
  - start pulse during a sweep is ignored; the beat count is unchanged.
  - rst asserted after 5 beats clears m_valid, enb and busy asynchronously. A new start then produces a clean full sweep from addr 0.
